// File: rtl/hoeraa_pkg.sv
// Shared definitions for the HOERAA error monitor.
// Default widths, FSM state encoding and the error-distance width helper.
package hoeraa_pkg;

    localparam int HOERAA_N     = 16;
    localparam int HOERAA_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic int ed_w(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/hoeraa_ed_calc.sv
// Exact-sum / approximate-result formation and unsigned error distance.
// The ED half operates on the registered stage-A values.
import hoeraa_pkg::*;

module hoeraa_ed_calc #(
    parameter int N = HOERAA_N
) (
    input  logic [N-1:0]         x_i,
    input  logic [N-1:0]         y_i,
    input  logic [N-1:0]         s_apx_i,
    input  logic                 co_apx_i,
    input  logic [ed_w(N)-1:0]   ex_r_i,
    input  logic [ed_w(N)-1:0]   ap_r_i,
    output logic [ed_w(N)-1:0]   ex_o,
    output logic [ed_w(N)-1:0]   ap_o,
    output logic [ed_w(N)-1:0]   ed_o
);

    always_comb begin
        ex_o = {1'b0, x_i} + {1'b0, y_i};
        ap_o = {co_apx_i, s_apx_i};
        ed_o = (ex_r_i >= ap_r_i) ? (ex_r_i - ap_r_i)
                                  : (ap_r_i - ex_r_i);
    end

endmodule

// File: rtl/hoeraa_error_monitor.sv
// Error monitor for the HOERAA approximate adder: runs a programmed number
// of samples through a 2-stage ED pipeline and accumulates error statistics.
import hoeraa_pkg::*;

module hoeraa_error_monitor #(
    parameter int N     = HOERAA_N,
    parameter int CNT_W = HOERAA_CNT_W,
    parameter int ACC_W = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       x,
    input  logic [N-1:0]       y,
    input  logic [N-1:0]       s_apx,
    input  logic               co_apx,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [ACC_W-1:0]   sum_ed,
    output logic [N:0]         max_ed,
    output logic               err_sat
);

    localparam int EW = ed_w(N);
    localparam int SW = ((ACC_W > EW) ? ACC_W : EW) + 1;

    state_t           state_q;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] acc_q;

    logic             va_q;
    logic             vb_q;
    logic [EW-1:0]    ex_q;
    logic [EW-1:0]    ap_q;
    logic [EW-1:0]    ed_q;

    logic [CNT_W-1:0] sample_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [ACC_W-1:0] sum_ed_q;
    logic [ACC_W-1:0] sum_ed_d;
    logic [EW-1:0]    max_ed_q;
    logic             err_sat_q;

    logic [EW-1:0]    ex;
    logic [EW-1:0]    ap;
    logic [EW-1:0]    ed;
    logic [SW-1:0]    sum_wide;
    logic             sum_ovf;
    logic             accept;
    logic             clear;

    hoeraa_ed_calc #(.N(N)) u_ed (
        .x_i      (x),
        .y_i      (y),
        .s_apx_i  (s_apx),
        .co_apx_i (co_apx),
        .ex_r_i   (ex_q),
        .ap_r_i   (ap_q),
        .ex_o     (ex),
        .ap_o     (ap),
        .ed_o     (ed)
    );

    assign in_ready = (state_q == RUN) && (acc_q < target_q);
    assign accept   = in_valid && in_ready;
    assign clear    = start && (state_q == IDLE || state_q == DONE);
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            acc_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        target_q <= num_samples;
                        acc_q    <= '0;
                        state_q  <= (num_samples == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_q <= acc_q + CNT_W'(1);
                        if (acc_q + CNT_W'(1) == target_q)
                            state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!va_q && !vb_q)
                        state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sum is widened by one bit beyond both operands so overflow is exact.
    always_comb begin
        sum_wide = SW'(sum_ed_q) + SW'(ed_q);
        sum_ovf  = |sum_wide[SW-1:ACC_W];
        sum_ed_d = sum_ovf ? '1 : sum_wide[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            va_q         <= 1'b0;
            vb_q         <= 1'b0;
            ex_q         <= '0;
            ap_q         <= '0;
            ed_q         <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_ed_q     <= '0;
            max_ed_q     <= '0;
            err_sat_q    <= 1'b0;
        end else begin
            va_q <= accept;
            vb_q <= va_q;
            if (accept) begin
                ex_q <= ex;
                ap_q <= ap;
            end
            if (va_q)
                ed_q <= ed;
            if (clear) begin
                sample_cnt_q <= '0;
                err_cnt_q    <= '0;
                sum_ed_q     <= '0;
                max_ed_q     <= '0;
                err_sat_q    <= 1'b0;
            end else if (vb_q) begin
                sample_cnt_q <= sample_cnt_q + CNT_W'(1);
                if (ed_q != '0)
                    err_cnt_q <= err_cnt_q + CNT_W'(1);
                sum_ed_q  <= sum_ed_d;
                err_sat_q <= err_sat_q | sum_ovf;
                if (ed_q > max_ed_q)
                    max_ed_q <= ed_q;
            end
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign sum_ed     = sum_ed_q;
    assign max_ed     = max_ed_q;
    assign err_sat    = err_sat_q;

endmodule

// File: tb/tb_hoeraa_error_monitor.sv
// Self-checking bench for hoeraa_error_monitor: vector table, scoreboard
// of per-sample ED, and hand-written multi-cycle corner sequences.
module tb_hoeraa_error_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] num_samples = '0;
    logic        in_valid = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic [15:0] s_apx = '0;
    logic        co_apx = 1'b0;

    logic        in_ready, busy, done, err_sat;
    logic [31:0] sample_cnt, err_cnt;
    logic [47:0] sum_ed;
    logic [16:0] max_ed;

    logic        in_ready4, busy4, done4, err_sat4;
    logic [31:0] sample_cnt4, err_cnt4;
    logic [3:0]  sum_ed4;
    logic [16:0] max_ed4;

    hoeraa_error_monitor dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .num_samples(num_samples), .in_valid(in_valid),
        .in_ready(in_ready), .x(x), .y(y), .s_apx(s_apx),
        .co_apx(co_apx), .busy(busy), .done(done),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt),
        .sum_ed(sum_ed), .max_ed(max_ed), .err_sat(err_sat)
    );

    hoeraa_error_monitor #(.ACC_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .num_samples(num_samples), .in_valid(in_valid),
        .in_ready(in_ready4), .x(x), .y(y), .s_apx(s_apx),
        .co_apx(co_apx), .busy(busy4), .done(done4),
        .sample_cnt(sample_cnt4), .err_cnt(err_cnt4),
        .sum_ed(sum_ed4), .max_ed(max_ed4), .err_sat(err_sat4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] s;
        logic        co;
        int          ed;
    } vec_t;

    vec_t tbl[7];
    vec_t stim_q[$];
    int   exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   acc_n = 0;

    function automatic int model_ed(input vec_t v);
        int ex;
        int ap;
        ex = int'(v.x) + int'(v.y);
        ap = (v.co ? 65536 : 0) + int'(v.s);
        return (ex > ap) ? ex - ap : ap - ex;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        logic [16:0] e;
        v.x = 16'($urandom);
        v.y = 16'($urandom);
        e = {1'b0, v.x} + {1'b0, v.y};
        if ($urandom_range(0, 1) == 1)
            e = e ^ 17'($urandom_range(1, 255));
        v.s = e[15:0];
        v.co = e[16];
        v.ed = 0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic vld);
        x = v.x;
        y = v.y;
        s_apx = v.s;
        co_apx = v.co;
        in_valid = vld;
    endtask

    task automatic do_start(input logic [31:0] n);
        @(negedge clk);
        start = 1'b1;
        num_samples = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input bit toggle);
        int budget;
        int cyc;
        budget = 200;
        cyc = 0;
        while (stim_q.size() > 0 && budget > 0) begin
            drive(stim_q[0], toggle ? (cyc % 2 == 0) : 1'b1);
            if (in_valid && in_ready) begin
                exp_q.push_back(model_ed(stim_q[0]));
                void'(stim_q.pop_front());
                acc_n++;
            end
            @(negedge clk);
            cyc++;
            budget--;
        end
        in_valid = 1'b0;
        if (stim_q.size() > 0) begin
            chk("feed_timeout", 64'(stim_q.size()), 64'd0);
            stim_q.delete();
        end
    endtask

    task automatic wait_done(input string nm);
        int b;
        b = 0;
        while (!done && b < 50) begin
            @(negedge clk);
            b++;
        end
        chk({nm, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic check_run(input string nm);
        longint cnt, err, sum, mx;
        int e;
        cnt = 0; err = 0; sum = 0; mx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cnt++;
            if (e != 0) err++;
            sum += e;
            if (e > mx) mx = e;
        end
        chk({nm, "_cnt"}, 64'(sample_cnt), 64'(cnt));
        chk({nm, "_err"}, 64'(err_cnt), 64'(err));
        chk({nm, "_sum"}, 64'(sum_ed), 64'(sum));
        chk({nm, "_max"}, 64'(max_ed), 64'(mx));
        chk({nm, "_sat"}, 64'(err_sat), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_done"}, 64'(done), 64'd0);
        chk({nm, "_rdy"}, 64'(in_ready), 64'd0);
        chk({nm, "_cnt"}, 64'(sample_cnt), 64'd0);
        chk({nm, "_err"}, 64'(err_cnt), 64'd0);
        chk({nm, "_sum"}, 64'(sum_ed), 64'd0);
        chk({nm, "_max"}, 64'(max_ed), 64'd0);
        chk({nm, "_sat"}, 64'(err_sat), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl[0] = '{16'h0001, 16'h0001, 16'h0002, 1'b0, 0};
        tbl[1] = '{16'h00FF, 16'h00FF, 16'h01FF, 1'b0, 1};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1};
        tbl[3] = '{16'h5555, 16'hAAAA, 16'hFFFF, 1'b0, 0};
        tbl[4] = '{16'h8001, 16'h0101, 16'h8100, 1'b0, 2};
        tbl[5] = '{16'h0000, 16'h0000, 16'hFFFF, 1'b1, 131071};
        tbl[6] = '{16'h1234, 16'h4321, 16'h5555, 1'b1, 65536};

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle");

        // Latency of one exact sample.
        do_start(32'd1);
        drive(tbl[0], 1'b1);
        chk("lat_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_t0", 64'(sample_cnt), 64'd0);
        @(negedge clk);
        chk("lat_t1", 64'(sample_cnt), 64'd0);
        @(negedge clk);
        chk("lat_t2", 64'(sample_cnt), 64'd1);
        wait_done("lat");
        chk("lat_err", 64'(err_cnt), 64'd0);
        chk("lat_sum", 64'(sum_ed), 64'd0);

        for (int i = 0; i < 7; i++) begin
            stim_q.push_back(tbl[i]);
            do_start(32'd1);
            feed(1'b0);
            wait_done($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_ed", i), 64'(sum_ed), 64'(tbl[i].ed));
            chk($sformatf("tbl%0d_mx", i), 64'(max_ed), 64'(tbl[i].ed));
            check_run($sformatf("tbl%0d", i));
        end

        stim_q.push_back(tbl[2]);
        stim_q.push_back(tbl[3]);
        stim_q.push_back(tbl[4]);
        do_start(32'd3);
        feed(1'b0);
        wait_done("three");
        chk("three_cnt_k", 64'(sample_cnt), 64'd3);
        chk("three_err_k", 64'(err_cnt), 64'd2);
        chk("three_sum_k", 64'(sum_ed), 64'd3);
        chk("three_max_k", 64'(max_ed), 64'd2);
        check_run("three");

        // Flow control with gaps, then extra valids after the last accept.
        acc_n = 0;
        for (int i = 0; i < 4; i++) stim_q.push_back(rand_vec());
        do_start(32'd4);
        feed(1'b1);
        chk("flow_rdy_drop", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            drive(rand_vec(), 1'b1);
            @(negedge clk);
            chk("flow_rdy_low", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        wait_done("flow");
        chk("flow_acc", 64'(acc_n), 64'd4);
        check_run("flow");

        do_start(32'd0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_cnt", 64'(sample_cnt), 64'd0);
        chk("zero_sum", 64'(sum_ed), 64'd0);
        chk("zero_busy", 64'(busy), 64'd0);

        // start while running must not restart or retarget the run.
        stim_q.push_back(tbl[1]);
        do_start(32'd3);
        feed(1'b0);
        start = 1'b1;
        num_samples = 32'd1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy", 64'(busy), 64'd1);
        stim_q.push_back(tbl[4]);
        stim_q.push_back(tbl[6]);
        feed(1'b0);
        wait_done("ign");
        check_run("ign");

        v = '{16'h0000, 16'h000F, 16'h0000, 1'b0, 15};
        stim_q.push_back(v);
        stim_q.push_back(v);
        do_start(32'd2);
        feed(1'b0);
        wait_done("sat");
        chk("sat4_sum", 64'(sum_ed4), 64'd15);
        chk("sat4_flag", 64'(err_sat4), 64'd1);
        chk("sat4_cnt", 64'(sample_cnt4), 64'd2);
        chk("sat4_err", 64'(err_cnt4), 64'd2);
        chk("sat4_max", 64'(max_ed4), 64'd15);
        chk("sat4_done", 64'(done4), 64'd1);
        chk("sat4_idle", 64'(busy4 | in_ready4), 64'd0);
        check_run("sat");

        // Abort mid-run with reset after 2 of 5 samples.
        v = tbl[4];
        stim_q.push_back(v);
        stim_q.push_back(v);
        do_start(32'd5);
        feed(1'b0);
        @(negedge clk);
        chk("pre_rst_cnt", 64'(sample_cnt), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        stim_q.push_back(tbl[1]);
        stim_q.push_back(tbl[6]);
        do_start(32'd2);
        feed(1'b0);
        wait_done("post_rst");
        check_run("post_rst");

        for (int i = 0; i < 20; i++) stim_q.push_back(rand_vec());
        do_start(32'd20);
        feed(1'b0);
        wait_done("rand");
        check_run("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
